iot_event_tx: RTL and testbench

- Event source for the active-IoT-device monitor counter, which consumes change/on_off pulses.
- Samples a vector of per-device on/off status lines and detects devices whose state differs from the state last reported.
- Serialises those differences into one change/on_off event per clock, with round-robin fairness.
- Keeps a mirror of the count it has reported, so the bench can cross-check the downstream counter.

---
 rtl/iot_event_tx.sv | 81 ++++++++
 tb/tb_iot_event_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/iot_event_tx.sv
// Event source for the active-device monitor: compares sampled per-device status with
// the last reported state and serialises differences as round-robin change/on_off events.
module iot_event_tx #(
    parameter int N_DEV = 8,
    parameter int ID_W  = $clog2(N_DEV),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_status,
    input  logic             enable,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic [CNT_W-1:0] active_count,
    output logic             busy
);

    logic [N_DEV-1:0] status_q;
    logic [N_DEV-1:0] reported;
    logic [N_DEV-1:0] pending;
    logic [ID_W-1:0]  rr_ptr;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  next_ptr;

    // A device whose sampled state matches what was last reported needs no event,
    // which is also how an even number of toggles cancels itself.
    assign pending = status_q ^ reported;
    assign busy    = |pending;

    // Round-robin search: first pending device at or above rr_ptr, wrapping at N_DEV.
    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 0; i < N_DEV; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_DEV) begin
                idx = idx - N_DEV;
            end
            if (!grant_vld && pending[idx]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    assign next_ptr = (grant_idx == ID_W'(N_DEV - 1)) ? '0 : grant_idx + ID_W'(1);

    // NOTE: registered state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q     <= '0;
            reported     <= '0;
            rr_ptr       <= '0;
            change       <= 1'b0;
            on_off       <= 1'b0;
            dev_id       <= '0;
            active_count <= '0;
        end else begin
            status_q <= dev_status;
            change   <= 1'b0;
            on_off   <= 1'b0;
            dev_id   <= '0;
            if (enable && grant_vld) begin
                change              <= 1'b1;
                on_off              <= status_q[grant_idx];
                dev_id              <= grant_idx;
                reported[grant_idx] <= status_q[grant_idx];
                rr_ptr              <= next_ptr;
                // Mirror tracks popcount(reported) by stepping once per reported transition.
                active_count        <= status_q[grant_idx] ? active_count + CNT_W'(1)
                                                           : active_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_iot_event_tx.sv
// Randomised + directed bench for iot_event_tx: a per-cycle reference model feeds an
// expected-event queue that an independent negedge monitor drains and compares.
module tb_iot_event_tx;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] dev_status = 8'h00;

    logic       change, on_off, busy;
    logic [2:0] dev_id;
    logic [7:0] active_count;
    logic       change3, on_off3, busy3;
    logic [2:0] dev_id3;
    logic [2:0] active_count3;

    iot_event_tx #(.N_DEV(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .dev_status(dev_status), .enable(enable),
        .change(change), .on_off(on_off), .dev_id(dev_id),
        .active_count(active_count), .busy(busy)
    );

    // Narrow mirror counter instance to exercise the modulo wrap.
    iot_event_tx #(.N_DEV(8), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .dev_status(dev_status), .enable(enable),
        .change(change3), .on_off(on_off3), .dev_id(dev_id3),
        .active_count(active_count3), .busy(busy3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit on;
        int cnt;
    } ev_t;

    ev_t exp_q[$];
    bit  m_status[N];
    bit  m_rep[N];
    int  m_rr;
    int  m_cnt;
    bit  started;
    int  n_pass;
    int  n_checks;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int popcount_rep();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += int'(m_rep[i]);
        return s;
    endfunction

    // Reference model: what has been reported vs. what was last sampled, rotating priority.
    always @(posedge clk) begin : model
        int  gd;
        bit  found;
        started = 1'b1;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_status[i] = 1'b0;
                m_rep[i]    = 1'b0;
            end
            m_rr  = 0;
            m_cnt = 0;
        end else begin
            found = 1'b0;
            gd    = 0;
            if (enable) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && (m_status[(m_rr + k) % N] != m_rep[(m_rr + k) % N])) begin
                        found = 1'b1;
                        gd    = (m_rr + k) % N;
                    end
                end
            end
            if (found) begin
                m_rep[gd] = m_status[gd];
                m_rr      = (gd + 1) % N;
                m_cnt     = popcount_rep();
                exp_q.push_back('{id: gd, on: m_rep[gd], cnt: m_cnt});
            end
            for (int i = 0; i < N; i++) m_status[i] = dev_status[i];
        end
    end

    always @(negedge clk) begin : monitor
        ev_t e;
        int  pend;
        if (started) begin
            pend = 0;
            for (int i = 0; i < N; i++) pend += int'(m_status[i] != m_rep[i]);
            check("busy", 64'(busy), 64'(pend != 0));
            if (change) begin
                if (exp_q.size() == 0) begin
                    check("spurious_event", 64'(change), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("dev_id", 64'(dev_id), 64'(e.id));
                    check("on_off", 64'(on_off), 64'(e.on));
                    check("active_count", 64'(active_count), 64'(e.cnt % 256));
                    check("active_count3", 64'(active_count3), 64'(e.cnt % 8));
                    check("dev_id3", 64'(dev_id3), 64'(e.id));
                end
            end else begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("missing_event", 64'(change), 64'(1));
                end
                check("idle_outputs", 64'({on_off, dev_id}), 64'(0));
                check("idle_count", 64'(active_count), 64'(m_cnt % 256));
                check("idle_count3", 64'(active_count3), 64'(m_cnt % 8));
                check("idle_change3", 64'(change3), 64'(0));
            end
        end
    end

    task automatic drive(input logic [7:0] st, input logic en, input logic r, input int n);
        dev_status = st;
        enable     = en;
        rst        = r;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] st;
        n_pass   = 0;
        n_checks = 0;

        // Reset replay with every device on.
        drive(8'hFF, 1'b0, 1'b1, 3);
        check("reset_change", 64'(change), 64'(0));
        check("reset_count", 64'(active_count), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        drive(8'hFF, 1'b1, 1'b0, 12);
        check("replay_count", 64'(active_count), 64'(8));
        check("replay_count3_wrap", 64'(active_count3), 64'(0));
        check("replay_busy", 64'(busy), 64'(0));
        drive(8'hFE, 1'b1, 1'b0, 4);
        check("wrap_dev0_off", 64'(active_count3), 64'(7));
        drive(8'h00, 1'b1, 1'b0, 12);

        // Single event: exactly one cycle of change after the sampling edge.
        drive(8'h04, 1'b1, 1'b0, 1);
        check("single_not_yet", 64'(change), 64'(0));
        drive(8'h04, 1'b1, 1'b0, 1);
        check("single_change", 64'(change), 64'(1));
        check("single_id", 64'(dev_id), 64'(2));
        check("single_count", 64'(active_count), 64'(1));
        drive(8'h04, 1'b1, 1'b0, 1);
        check("single_pulse_end", 64'(change), 64'(0));
        drive(8'h00, 1'b1, 1'b0, 4);

        // Round-robin: devices 1 and 6 pending together after a grant to device 2.
        drive(8'h42, 1'b1, 1'b0, 4);
        drive(8'h00, 1'b1, 1'b0, 4);

        // Cancellation: even toggles vanish, odd toggles report once.
        drive(8'h20, 1'b0, 1'b0, 3);
        drive(8'h00, 1'b0, 1'b0, 2);
        drive(8'h00, 1'b1, 1'b0, 4);
        check("cancel_count", 64'(active_count), 64'(0));
        check("cancel_busy", 64'(busy), 64'(0));
        drive(8'h20, 1'b0, 1'b0, 2);
        drive(8'h00, 1'b0, 1'b0, 2);
        drive(8'h20, 1'b0, 1'b0, 2);
        drive(8'h20, 1'b1, 1'b0, 3);
        check("odd_toggle_count", 64'(active_count), 64'(1));
        drive(8'h00, 1'b1, 1'b0, 4);

        // Reset mid-burst, then full re-announcement.
        drive(8'hF0, 1'b1, 1'b0, 3);
        drive(8'hF0, 1'b1, 1'b1, 1);
        check("midreset_change", 64'(change), 64'(0));
        check("midreset_count", 64'(active_count), 64'(0));
        drive(8'hF0, 1'b1, 1'b0, 8);
        check("midreset_replay_count", 64'(active_count), 64'(4));
        drive(8'h00, 1'b1, 1'b0, 8);

        // Random toggling, enable gaps and occasional resets.
        st = 8'h00;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) st = st ^ (8'h01 << $urandom_range(0, 7));
            drive(st, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0), 1);
        end
        drive(st, 1'b1, 1'b0, 12);
        check("drain_busy", 64'(busy), 64'(0));
        check("drain_queue", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
